// File: rtl/psr_window_unit_if.sv
// Condition-code / register-window request and status bundle between the ALU-side
// controller (master) and psr_window_unit (slave).
interface psr_window_unit_if #(
    parameter int NWIN   = 8,
    parameter int FLAG_W = 4
);
    localparam int CWP_W = (NWIN > 2) ? $clog2(NWIN) : 1;

    logic [FLAG_W-1:0] flags_in;
    logic              flag_ld;
    logic [FLAG_W-1:0] flag_mask;
    logic              wim_ld;
    logic [NWIN-1:0]   wim_in;
    logic              save;
    logic              restore;
    logic              trap;
    logic              rett;

    logic [FLAG_W-1:0] flags_out;
    logic [CWP_W-1:0]  cwp;
    logic [NWIN-1:0]   wim;
    logic              et;
    logic              win_ovf;
    logic              win_unf;
    logic              err_mode;
    logic              rett_ill;

    modport master (
        output flags_in, flag_ld, flag_mask, wim_ld, wim_in, save, restore, trap, rett,
        input  flags_out, cwp, wim, et, win_ovf, win_unf, err_mode, rett_ill
    );

    modport slave (
        input  flags_in, flag_ld, flag_mask, wim_ld, wim_in, save, restore, trap, rett,
        output flags_out, cwp, wim, et, win_ovf, win_unf, err_mode, rett_ill
    );
endinterface

// File: rtl/psr_window_unit.sv
// Condition codes plus SPARC CWP/WIM/ET state; resolves SAVE/RESTORE/trap/RETT window moves.
// Single-cycle: all state and exception pulses registered, no backpressure (every request decided at its edge).
module psr_window_unit #(
    parameter int NWIN   = 8,
    parameter int FLAG_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    psr_window_unit_if.slave bus
);
    localparam int CWP_W = (NWIN > 2) ? $clog2(NWIN) : 1;
    localparam logic [CWP_W-1:0] CWP_LAST = CWP_W'(NWIN - 1);

    logic [FLAG_W-1:0] flags_q, flags_n, flag_wr;
    logic [CWP_W-1:0]  cwp_q, cwp_n, cwp_dec, cwp_inc;
    logic [NWIN-1:0]   wim_q, wim_n;
    logic              et_q, et_n;
    logic              ovf_q, ovf_n, unf_q, unf_n, err_q, err_n, rill_q, rill_n;

    // Explicit wrap compares: NWIN need not be a power of two.
    assign cwp_dec = (cwp_q == '0)       ? CWP_LAST : cwp_q - CWP_W'(1);
    assign cwp_inc = (cwp_q == CWP_LAST) ? '0       : cwp_q + CWP_W'(1);

    assign flag_wr = {FLAG_W{bus.flag_ld}} & bus.flag_mask;
    assign flags_n = (flags_q & ~flag_wr) | (bus.flags_in & flag_wr);
    assign wim_n   = bus.wim_ld ? bus.wim_in : wim_q;

    // Only the highest-priority request acts; all window decisions use wim_q, not wim_in.
    always_comb begin
        cwp_n  = cwp_q;
        et_n   = et_q;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        err_n  = 1'b0;
        rill_n = 1'b0;
        if (bus.trap) begin
            if (et_q) begin
                cwp_n = cwp_dec;
                et_n  = 1'b0;
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.rett) begin
            if (et_q) begin
                rill_n = 1'b1;
            end else if (wim_q[cwp_inc]) begin
                unf_n = 1'b1;
            end else begin
                cwp_n = cwp_inc;
                et_n  = 1'b1;
            end
        end else if (bus.save) begin
            if (wim_q[cwp_dec]) ovf_n = 1'b1;
            else                cwp_n = cwp_dec;
        end else if (bus.restore) begin
            if (wim_q[cwp_inc]) unf_n = 1'b1;
            else                cwp_n = cwp_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
            cwp_q   <= '0;
            wim_q   <= '0;
            et_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
            rill_q  <= 1'b0;
        end else begin
            flags_q <= flags_n;
            cwp_q   <= cwp_n;
            wim_q   <= wim_n;
            et_q    <= et_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
            err_q   <= err_n;
            rill_q  <= rill_n;
        end
    end

    assign bus.flags_out = flags_q;
    assign bus.cwp       = cwp_q;
    assign bus.wim       = wim_q;
    assign bus.et        = et_q;
    assign bus.win_ovf   = ovf_q;
    assign bus.win_unf   = unf_q;
    assign bus.err_mode  = err_q;
    assign bus.rett_ill  = rill_q;
endmodule

// File: tb/tb_psr_window_unit.sv
// Directed bench for psr_window_unit at NWIN=8/5/2 sharing one stimulus, with an integer-level model.
module tb_psr_window_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flags_in, flag_mask;
    logic        flag_ld, wim_ld, save, restore, trap, rett;
    logic [31:0] wim_in;
    bit          chk_en = 1'b0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    psr_window_unit_if #(.NWIN(8), .FLAG_W(4)) b8 ();
    psr_window_unit_if #(.NWIN(5), .FLAG_W(4)) b5 ();
    psr_window_unit_if #(.NWIN(2), .FLAG_W(4)) b2 ();

    assign b8.flags_in = flags_in;  assign b5.flags_in = flags_in;  assign b2.flags_in = flags_in;
    assign b8.flag_ld = flag_ld;    assign b5.flag_ld = flag_ld;    assign b2.flag_ld = flag_ld;
    assign b8.flag_mask = flag_mask; assign b5.flag_mask = flag_mask; assign b2.flag_mask = flag_mask;
    assign b8.wim_ld = wim_ld;      assign b5.wim_ld = wim_ld;      assign b2.wim_ld = wim_ld;
    assign b8.wim_in = wim_in[7:0]; assign b5.wim_in = wim_in[4:0]; assign b2.wim_in = wim_in[1:0];
    assign b8.save = save;          assign b5.save = save;          assign b2.save = save;
    assign b8.restore = restore;    assign b5.restore = restore;    assign b2.restore = restore;
    assign b8.trap = trap;          assign b5.trap = trap;          assign b2.trap = trap;
    assign b8.rett = rett;          assign b5.rett = rett;          assign b2.rett = rett;

    psr_window_unit #(.NWIN(8), .FLAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    psr_window_unit #(.NWIN(5), .FLAG_W(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));
    psr_window_unit #(.NWIN(2), .FLAG_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    // DUT observations, widened; pulse vector is {rett_ill, err_mode, win_unf, win_ovf}.
    logic [31:0] o_cwp [3];
    logic [31:0] o_wim [3];
    logic [3:0]  o_fl  [3];
    logic        o_et  [3];
    logic [3:0]  o_p   [3];
    assign o_cwp[0] = 32'(b8.cwp); assign o_cwp[1] = 32'(b5.cwp); assign o_cwp[2] = 32'(b2.cwp);
    assign o_wim[0] = 32'(b8.wim); assign o_wim[1] = 32'(b5.wim); assign o_wim[2] = 32'(b2.wim);
    assign o_fl[0] = b8.flags_out; assign o_fl[1] = b5.flags_out; assign o_fl[2] = b2.flags_out;
    assign o_et[0] = b8.et;        assign o_et[1] = b5.et;        assign o_et[2] = b2.et;
    assign o_p[0] = {b8.rett_ill, b8.err_mode, b8.win_unf, b8.win_ovf};
    assign o_p[1] = {b5.rett_ill, b5.err_mode, b5.win_unf, b5.win_ovf};
    assign o_p[2] = {b2.rett_ill, b2.err_mode, b2.win_unf, b2.win_ovf};

    function automatic int nw(int d);
        return (d == 0) ? 8 : ((d == 1) ? 5 : 2);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: window index arithmetic done modulo n on plain integers.
    int          m_cwp [3];
    bit          m_et  [3];
    logic [31:0] m_wim [3];
    logic [3:0]  m_fl  [3];
    logic [3:0]  m_p   [3];

    always @(posedge clk) begin : model
        int n, dn, up;
        for (int d = 0; d < 3; d++) begin
            n  = nw(d);
            dn = (m_cwp[d] + n - 1) % n;
            up = (m_cwp[d] + 1) % n;
            if (!rst_n) begin
                m_cwp[d] <= 0; m_et[d] <= 1'b0; m_wim[d] <= '0; m_fl[d] <= '0; m_p[d] <= '0;
            end else begin
                m_p[d] <= 4'b0000;
                for (int i = 0; i < 4; i++)
                    if (flag_ld && flag_mask[i]) m_fl[d][i] <= flags_in[i];
                if (trap) begin
                    if (m_et[d]) begin m_cwp[d] <= dn; m_et[d] <= 1'b0; end
                    else m_p[d] <= 4'b0100;
                end else if (rett) begin
                    if (m_et[d]) m_p[d] <= 4'b1000;
                    else if (m_wim[d][up]) m_p[d] <= 4'b0010;
                    else begin m_cwp[d] <= up; m_et[d] <= 1'b1; end
                end else if (save) begin
                    if (m_wim[d][dn]) m_p[d] <= 4'b0001;
                    else m_cwp[d] <= dn;
                end else if (restore) begin
                    if (m_wim[d][up]) m_p[d] <= 4'b0010;
                    else m_cwp[d] <= up;
                end
                if (wim_ld) m_wim[d] <= wim_in & ((32'h1 << n) - 32'h1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("cwp[n=%0d]", nw(d)), o_cwp[d], 32'(m_cwp[d]));
                chk($sformatf("et[n=%0d]", nw(d)), 32'(o_et[d]), 32'(m_et[d]));
                chk($sformatf("wim[n=%0d]", nw(d)), o_wim[d], m_wim[d]);
                chk($sformatf("flags[n=%0d]", nw(d)), 32'(o_fl[d]), 32'(m_fl[d]));
                chk($sformatf("pulses[n=%0d]", nw(d)), 32'(o_p[d]), 32'(m_p[d]));
                chk($sformatf("pulse_excl[n=%0d]", nw(d)), 32'($onehot0(o_p[d])), 32'd1);
            end
        end
    end

    task automatic clr();
        flag_ld = 1'b0; flag_mask = '0; flags_in = '0; wim_ld = 1'b0; wim_in = '0;
        save = 1'b0; restore = 1'b0; trap = 1'b0; rett = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // Reset with requests active
        rst_n = 1'b0; flag_ld = 1'b1; flag_mask = 4'hF; flags_in = 4'hF;
        wim_ld = 1'b1; wim_in = '1; save = 1'b1; trap = 1'b1; restore = 1'b0; rett = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_flags", 32'(b8.flags_out), 32'h0);
        chk("rst_cwp", 32'(b8.cwp), 32'h0);
        chk("rst_wim", 32'(b8.wim), 32'h0);
        chk("rst_et", 32'(b8.et), 32'h0);
        chk("rst_pulses", 32'(o_p[0]), 32'h0);

        clr(); rst_n = 1'b1;
        flag_ld = 1'b1; flags_in = 4'b1010; flag_mask = 4'b0011; tick();
        chk("flags_mask_lo", 32'(b8.flags_out), 32'b0010);
        flags_in = 4'b0101; flag_mask = 4'b1100; tick();
        chk("flags_mask_hi", 32'(b8.flags_out), 32'b0110);
        clr();

        // Wrap: save from 0 in all three widths, then eight restores
        save = 1'b1; tick(); clr();
        chk("save_wrap_n8", 32'(b8.cwp), 32'd7);
        chk("save_wrap_n5", 32'(b5.cwp), 32'd4);
        chk("save_wrap_n2", 32'(b2.cwp), 32'd1);
        restore = 1'b1; tick();
        chk("restore_wrap_to0", 32'(b8.cwp), 32'd0);
        repeat (7) tick();
        chk("restore_x8", 32'(b8.cwp), 32'd7);
        clr();

        // restore to 0 while loading wim=0x80 (old wim=0 decides)
        restore = 1'b1; wim_ld = 1'b1; wim_in = 32'h80; tick(); clr();
        chk("cwp_zero", 32'(b8.cwp), 32'd0);
        save = 1'b1; tick(); clr();
        chk("ovf_pulse", 32'(b8.win_ovf), 32'd1);
        chk("ovf_cwp_hold", 32'(b8.cwp), 32'd0);
        tick();
        chk("ovf_deassert", 32'(b8.win_ovf), 32'd0);
        restore = 1'b1; tick(); clr();
        chk("restore_to1", 32'(b8.cwp), 32'd1);
        wim_ld = 1'b1; wim_in = 32'h04; tick(); clr();
        restore = 1'b1; tick(); clr();
        chk("unf_pulse", 32'(b8.win_unf), 32'd1);
        chk("unf_cwp_hold", 32'(b8.cwp), 32'd1);

        // Trap / RETT
        trap = 1'b1; tick(); clr();
        chk("err_mode", 32'(b8.err_mode), 32'd1);
        chk("err_cwp_hold", 32'(b8.cwp), 32'd1);
        wim_ld = 1'b1; wim_in = '0; tick(); clr();
        restore = 1'b1; tick(); tick(); clr();
        chk("cwp_3", 32'(b8.cwp), 32'd3);
        rett = 1'b1; tick(); clr();
        chk("rett_cwp", 32'(b8.cwp), 32'd4);
        chk("rett_et", 32'(b8.et), 32'd1);
        trap = 1'b1; tick(); clr();
        chk("trap_cwp", 32'(b8.cwp), 32'd3);
        chk("trap_et", 32'(b8.et), 32'd0);
        rett = 1'b1; tick(); tick(); clr();
        chk("rett_ill", 32'(b8.rett_ill), 32'd1);
        chk("rett_ill_cwp", 32'(b8.cwp), 32'd4);

        // Priority: trap wins over save+restore
        restore = 1'b1; tick(); clr();
        save = 1'b1; restore = 1'b1; trap = 1'b1; tick(); clr();
        chk("prio_cwp", 32'(b8.cwp), 32'd4);
        chk("prio_et", 32'(b8.et), 32'd0);
        chk("prio_no_pulse", 32'(o_p[0]), 32'd0);
        save = 1'b1; wim_ld = 1'b1; wim_in = 32'h08; tick(); clr();
        chk("save_wimld_cwp", 32'(b8.cwp), 32'd3);
        chk("save_wimld_wim", 32'(b8.wim), 32'h08);

        // All-ones WIM blocks everything
        wim_ld = 1'b1; wim_in = '1; tick(); clr();
        save = 1'b1; tick(); clr();
        chk("ones_save", 32'(o_p[0]), 32'b0001);
        restore = 1'b1; tick(); clr();
        chk("ones_restore", 32'(o_p[0]), 32'b0010);
        rett = 1'b1; tick(); clr();
        chk("ones_rett", 32'(o_p[0]), 32'b0010);
        chk("ones_cwp", 32'(b8.cwp), 32'd3);

        // Mid-operation reset
        rst_n = 1'b0; rett = 1'b1; tick(); clr(); rst_n = 1'b1;
        chk("midrst_cwp", 32'(b8.cwp), 32'd0);
        chk("midrst_wim", 32'(b8.wim), 32'd0);

        // Pseudo-random request stream, checked only by the model
        for (int k = 0; k < 400; k++) begin
            flags_in  = 4'($urandom);
            flag_mask = 4'($urandom);
            flag_ld   = ($urandom_range(0, 1) == 1);
            trap      = ($urandom_range(0, 5) == 0);
            rett      = ($urandom_range(0, 4) == 0);
            save      = ($urandom_range(0, 1) == 1);
            restore   = ($urandom_range(0, 1) == 1);
            wim_ld    = ($urandom_range(0, 7) == 0);
            wim_in    = $urandom & $urandom;
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end
        clr(); rst_n = 1'b1; tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/psr_window_unit.md
# psr_window_unit

Parametrised successor of the 4-bit flag register: holds the integer condition codes with per-bit write masking and adds the SPARC current-window-pointer (CWP), window-invalid mask (WIM) and enable-traps (ET) state. Sits beside the ALU and register-file window decoder. It resolves SAVE/RESTORE/trap/RETT window moves with wrap-around and overflow/underflow detection. It reports exceptions as registered one-cycle pulses to the trap controller.

## Interface
- NWIN, 8: number of register windows, 2..32; CWP wraps modulo NWIN (need not be a power of two).
- FLAG_W, 4: condition-code width (bit 3 N, 2 Z, 1 V, 0 C at default).
- CWP_W, $clog2(NWIN) (min 1): CWP width, derived, not overridden.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- flags_in  in  FLAG_W  new condition codes from ALU.
- flag_ld  in  1  load enable for flags.
- flag_mask  in  FLAG_W  per-bit write enable; bit written only if flag_ld & flag_mask[i].
- wim_ld  in  1  load WIM from wim_in.
- wim_in  in  NWIN  new WIM value.
- save  in  1  request CWP decrement with overflow check.
- restore  in  1  request CWP increment with underflow check.
- trap  in  1  trap entry: CWP decrement, no WIM check, ET cleared.
- rett  in  1  return from trap: CWP increment with underflow check, ET set.
- flags_out  out  FLAG_W  registered condition codes.
- cwp  out  CWP_W  registered current window pointer.
- wim  out  NWIN  registered window-invalid mask.
- et  out  1  registered enable-traps bit.
- win_ovf  out  1  one-cycle pulse: SAVE rejected.
- win_unf  out  1  one-cycle pulse: RESTORE/RETT rejected.
- err_mode  out  1  one-cycle pulse: trap while et=0.
- rett_ill  out  1  one-cycle pulse: rett while et=1.

## Operation
- Reset (rst_n=0 at posedge): flags_out=0, cwp=0, wim=0, et=0, all pulses 0. Reset overrides every other input that cycle, including mid-operation requests.
- Flags: flags_out[i] <= flags_in[i] when flag_ld & flag_mask[i], else hold. Fully independent of window operations; may coincide with any of them.
- dec = (cwp==0) ? NWIN-1 : cwp-1; inc = (cwp==NWIN-1) ? 0 : cwp+1. No other arithmetic on CWP.
- Window requests are prioritised trap > rett > save > restore. Only the highest active request is acted on; lower ones are dropped silently with no pulse.
- trap: if et=1 then cwp<=dec, et<=0. If et=0 then state holds and err_mode pulses.
- rett: if et=1 then state holds and rett_ill pulses. Else if wim[inc]=1 then state holds and win_unf pulses. Else cwp<=inc, et<=1.
- save: if wim[dec]=1 then cwp holds and win_ovf pulses. Else cwp<=dec.
- restore: if wim[inc]=1 then cwp holds and win_unf pulses. Else cwp<=inc.
- WIM checks use the WIM value before the edge. A wim_ld in the same cycle updates wim at that edge but does not affect the decision.
- Other behaviour:
  - save and restore are legal with any et value.
  - NWIN=2: dec and inc address the same window.
  - All-ones WIM blocks every save, restore and rett.

## Timing
- Single-cycle: every update is visible on outputs one cycle after the sampling edge.
- Pulses are registered. Each is high exactly one cycle after the offending request edge and deasserts the next cycle unless it is re-triggered.
- At most one of win_ovf/win_unf/err_mode/rett_ill is high in any cycle.
- Back-to-back requests on consecutive cycles each use the cwp produced by the previous edge. There is no bubble and no busy signal.

## Test plan
- Reset/flags: assert rst_n=0 with flag_ld=1 and save=1 → all outputs 0. Release, then flags_in=4'b1010 with mask 4'b0011 → flags_out=4'b0010. Next, flags_in=4'b0101 with mask 4'b1100 → flags_out=4'b0110.
- Wrap: NWIN=8, wim=0. One save from cwp=0 → cwp=7. Eight restores → cwp returns to 7, wrapping through 0.
- Overflow/underflow: wim=8'b1000_0000, cwp=0. save → win_ovf pulses one cycle, cwp stays 0. restore → cwp=1. wim=8'b0000_0100 with cwp=1, restore → win_unf, cwp stays 1.
- Trap/RETT: et=0, trap → err_mode, cwp unchanged. Manually rett with et=0, wim=0 from cwp=3 → cwp=4, et=1. trap → cwp=3, et=0. rett with et=1 → rett_ill.
- Priority/simultaneity: et=1, with save+restore+trap in the same cycle from cwp=5 → cwp=4, et=0, no pulse. Separately, save with wim_ld setting wim[dec]=1 in the same cycle → save succeeds, wim updated.
- Parameter sweep: NWIN=5 and NWIN=2. A save from 0 yields 4 and 1 respectively. Random request streams are checked against a reference model for cwp/et/pulse exclusivity.
